// File: rtl/chipset_boot_pkg.sv
// Shared definitions for the chipset boot sequencer: FSM states, interrupt
// packet constants and NoC header field positions.
package chipset_boot_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_CLKEN_WAIT,
    ST_RST_WAIT,
    ST_INIT_WAIT,
    ST_HDR,
    ST_PAYLOAD,
    ST_DONE
  } boot_state_e;

  localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'd32;
  localparam logic [7:0] PAYLOAD_LEN        = 8'd1;
  localparam logic [1:0] INT_TYPE_RESET     = 2'b01;
  localparam logic [4:0] INT_THREAD         = 5'd0;
  localparam logic [5:0] INT_VECTOR         = 6'd1;

  localparam int HDR_CHIPID_LSB  = 50;
  localparam int HDR_CHIPID_W    = 14;
  localparam int HDR_X_LSB       = 42;
  localparam int HDR_Y_LSB       = 34;
  localparam int HDR_COORD_W     = 8;
  localparam int HDR_FBITS_LSB   = 30;
  localparam int HDR_FBITS_W     = 4;
  localparam int HDR_LEN_LSB     = 22;
  localparam int HDR_MSGTYPE_LSB = 14;
  localparam int HDR_MSHR_LSB    = 6;
  localparam int HDR_BYTE_W      = 8;

  localparam int PLD_TYPE_LSB    = 16;
  localparam int PLD_THREAD_LSB  = 8;
  localparam int PLD_VECTOR_LSB  = 0;

  // A zero delay still spends one cycle in its wait state.
  function automatic int eff_dly(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chipset_boot_seq_if.sv
// Chipset-to-chip NoC1 flit channel with val/rdy handshake.
interface chipset_boot_seq_if;
  logic        noc_val;
  logic [63:0] noc_data;
  logic        noc_rdy;

  modport master (output noc_val, output noc_data, input noc_rdy);
  modport slave  (input noc_val, input noc_data, output noc_rdy);
endinterface

// File: rtl/boot_pkt_gen.sv
// Combinational builder for the reset-interrupt (wake-up) packet: one header
// flit addressed to chipid/x/y and one payload flit starting thread 0.
module boot_pkt_gen
  import chipset_boot_pkg::*;
(
  input  logic [13:0] i_chipid,
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  output logic [63:0] o_hdr,
  output logic [63:0] o_payload
);

  always_comb begin
    o_hdr = '0;
    o_hdr[HDR_CHIPID_LSB  +: HDR_CHIPID_W] = i_chipid;
    o_hdr[HDR_X_LSB       +: HDR_COORD_W]  = i_x;
    o_hdr[HDR_Y_LSB       +: HDR_COORD_W]  = i_y;
    o_hdr[HDR_FBITS_LSB   +: HDR_FBITS_W]  = '0;
    o_hdr[HDR_LEN_LSB     +: HDR_BYTE_W]   = PAYLOAD_LEN;
    o_hdr[HDR_MSGTYPE_LSB +: HDR_BYTE_W]   = MSG_TYPE_INTERRUPT;
    o_hdr[HDR_MSHR_LSB    +: HDR_BYTE_W]   = '0;
  end

  always_comb begin
    o_payload = '0;
    o_payload[PLD_TYPE_LSB   +: 2] = INT_TYPE_RESET;
    o_payload[PLD_THREAD_LSB +: 5] = INT_THREAD;
    o_payload[PLD_VECTOR_LSB +: 6] = INT_VECTOR;
  end

endmodule

// File: rtl/chipset_boot_seq.sv
// Chip power-up sequencer and wake-up packet transmitter.
// Define PITON_WAKEUP_ALL_TILES_EN to send one wake-up packet to every tile.
module chipset_boot_seq
  import chipset_boot_pkg::*;
#(
  parameter logic [13:0] CHIPID    = 14'd0,
  parameter logic [7:0]  DEST_X    = 8'd0,
  parameter logic [7:0]  DEST_Y    = 8'd0,
  parameter int          X_TILES   = 1,
  parameter int          NUM_TILES = 1,
  parameter int          CLKEN_DLY = 10,
  parameter int          RST_DLY   = 100,
  parameter int          INIT_DLY  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  output logic               clk_en,
  output logic               chip_rst_n,
  output logic               boot_done,
  chipset_boot_seq_if.master noc
);

  localparam int C_DLY   = eff_dly(CLKEN_DLY);
  localparam int R_DLY   = eff_dly(RST_DLY);
  localparam int I_DLY   = eff_dly(INIT_DLY);
  localparam int MAX_DLY = max3(C_DLY, R_DLY, I_DLY);
  localparam int CNT_W   = $clog2(MAX_DLY) + 1;

  logic [1:0]       r_sync;
  boot_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_dly_m1;
  logic             r_clk_en, r_chip_rst_n, r_boot_done, r_noc_val;
  logic [63:0]      r_noc_data;
  logic             w_lock_s, w_fire, w_last;
  logic [7:0]       w_x, w_y;
  logic [63:0]      w_hdr, w_payload;

  assign w_lock_s = r_sync[1];
  assign w_fire   = r_noc_val & noc.noc_rdy;

`ifdef PITON_WAKEUP_ALL_TILES_EN
  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [8:0]       w_idx_ext;

  assign w_last    = (r_idx == IDX_W'(NUM_TILES - 1));
  assign w_idx_nxt = (r_state == ST_PAYLOAD && w_fire && !w_last) ? r_idx + IDX_W'(1) : r_idx;
  // Coordinates follow the index the header is about to carry.
  assign w_idx_ext = 9'(w_idx_nxt);
  assign w_x       = 8'(w_idx_ext % 9'(X_TILES));
  assign w_y       = 8'(w_idx_ext / 9'(X_TILES));

  always_ff @(posedge clk) begin
    if (rst) r_idx <= '0;
    else     r_idx <= w_idx_nxt;
  end
`else
  assign w_last = 1'b1;
  assign w_x    = DEST_X;
  assign w_y    = DEST_Y;
`endif

  boot_pkt_gen u_pkt_gen (
    .i_chipid  (CHIPID),
    .i_x       (w_x),
    .i_y       (w_y),
    .o_hdr     (w_hdr),
    .o_payload (w_payload)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_dly_m1    = '0;
    unique case (r_state)
      ST_WAIT_LOCK:  if (w_lock_s) w_state_nxt = ST_CLKEN_WAIT;
      ST_CLKEN_WAIT: begin
        w_dly_m1 = CNT_W'(C_DLY - 1);
        if (r_cnt == w_dly_m1) w_state_nxt = ST_RST_WAIT;
      end
      ST_RST_WAIT: begin
        w_dly_m1 = CNT_W'(R_DLY - 1);
        if (r_cnt == w_dly_m1) w_state_nxt = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        w_dly_m1 = CNT_W'(I_DLY - 1);
        if (r_cnt == w_dly_m1) w_state_nxt = ST_HDR;
      end
      ST_HDR:        if (w_fire) w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD:    if (w_fire) w_state_nxt = w_last ? ST_DONE : ST_HDR;
      ST_DONE:       w_state_nxt = ST_DONE;
      default:       w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      r_sync       <= '0;
      r_state      <= ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_clk_en     <= 1'b0;
      r_chip_rst_n <= 1'b0;
      r_boot_done  <= 1'b0;
      r_noc_val    <= 1'b0;
      r_noc_data   <= '0;
    end else begin
      r_sync       <= {r_sync[0], pll_lock};
      r_state      <= w_state_nxt;
      r_cnt        <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_clk_en     <= !(w_state_nxt inside {ST_WAIT_LOCK, ST_CLKEN_WAIT});
      r_chip_rst_n <= !(w_state_nxt inside {ST_WAIT_LOCK, ST_CLKEN_WAIT, ST_RST_WAIT});
      r_boot_done  <= (w_state_nxt == ST_DONE);
      r_noc_val    <= (w_state_nxt inside {ST_HDR, ST_PAYLOAD});
      r_noc_data   <= (w_state_nxt == ST_HDR)     ? w_hdr :
                      (w_state_nxt == ST_PAYLOAD) ? w_payload : '0;
    end
  end

  assign clk_en       = r_clk_en;
  assign chip_rst_n   = r_chip_rst_n;
  assign boot_done    = r_boot_done;
  assign noc.noc_val  = r_noc_val;
  assign noc.noc_data = r_noc_data;

endmodule
